// File: rtl/ibnalhaytham_run_ctrl.sv
// Run/load controller: LA command decode, HALT/RUN/STEP sequencing, imem loader.
// Optional LOADER_CHECKSUM_EN adds a 16-bit write checksum on status[31:16].
module ibnalhaytham_run_ctrl #(
    parameter int ADDR_W = 10,
    parameter int STEP_W = 14
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       la1_data_in,
    input  logic [31:0]       la1_oenb,
    output logic [31:0]       la1_data_out,
    output logic              core_rst,
    output logic              core_clk_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                rst_q, rst_d;
    logic                clk_en_q, clk_en_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [15:0]         lo_q, lo_d;
    logic                half_q, half_d;
    logic                err_q, err_d;
    logic                tog_q, tog_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [15:0]         csum_q, csum_d;

    logic [1:0]  op;
    logic [15:0] pay;
    logic        acc;
    logic [9:0]  addr_ext;
    logic        unused_bits;

    assign op  = la1_data_in[31:30];
    assign pay = la1_data_in[15:0];
    assign acc = (la1_data_in[29] != tog_q) && (la1_oenb[31:29] == 3'b000) && !we_q;
    assign unused_bits = ^{la1_oenb[28:0], la1_data_in[28:16]};

    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        half_d  = half_q;
        err_d   = err_q;
        tog_d   = tog_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;

        if (state_q == S_STEP) begin
            if (cnt_q <= STEP_W'(1)) state_d = S_HALT;
            else cnt_d = cnt_q - STEP_W'(1);
        end

        if (we_q) begin
            we_d   = 1'b0;
            addr_d = addr_q + ADDR_W'(1);
        end else if (acc) begin
            tog_d = la1_data_in[29];
            case (op)
                2'b01: begin
                    if (state_q != S_HALT) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = pay[ADDR_W-1:0];
                        half_d = 1'b0;
                        csum_d = '0;
                    end
                end
                2'b10: begin
                    if (state_q != S_HALT) begin
                        err_d = 1'b1;
                    end else if (!half_q) begin
                        lo_d   = pay;
                        half_d = 1'b1;
                    end else begin
                        wdata_d = {pay, lo_q};
                        we_d    = 1'b1;
                        half_d  = 1'b0;
                        csum_d  = csum_q + lo_q + pay;
                    end
                end
                2'b11: begin
                    case (pay[15:14])
                        2'b00: state_d = S_HALT;
                        2'b01: begin
                            state_d = S_RUN;
                            rst_d   = 1'b0;
                        end
                        2'b10: begin
                            // a free-running core cannot be narrowed to a step
                            if (state_q == S_RUN) begin
                                err_d = 1'b1;
                            end else begin
                                cnt_d   = (pay[STEP_W-1:0] == '0) ? STEP_W'(1)
                                                                  : pay[STEP_W-1:0];
                                state_d = S_STEP;
                                rst_d   = 1'b0;
                            end
                        end
                        default: begin
                            state_d = S_HALT;
                            rst_d   = 1'b1;
                            err_d   = 1'b0;
                            half_d  = 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        clk_en_d = (state_d != S_HALT);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_HALT;
            rst_q    <= 1'b1;
            clk_en_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            half_q   <= 1'b0;
            err_q    <= 1'b0;
            tog_q    <= 1'b0;
            cnt_q    <= '0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            rst_q    <= rst_d;
            clk_en_q <= clk_en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            half_q   <= half_d;
            err_q    <= err_d;
            tog_q    <= tog_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
        end
    end

    assign addr_ext    = 10'(addr_q);
    assign core_rst    = rst_q;
    assign core_clk_en = clk_en_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;

`ifdef LOADER_CHECKSUM_EN
    assign la1_data_out = {csum_q, addr_ext, tog_q, err_q, half_q, rst_q, state_q};
`else
    logic unused_csum;
    assign unused_csum  = ^csum_q;
    assign la1_data_out = {16'h0000, addr_ext, tog_q, err_q, half_q, rst_q, state_q};
`endif

endmodule

// File: tb/tb_ibnalhaytham_run_ctrl.sv
// Scoreboard bench for ibnalhaytham_run_ctrl: stimulus queues expectations,
// negedge monitors pop and compare status, control and write-port outputs.
module tb_ibnalhaytham_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic [31:0] oenb = '0;
    logic [31:0] dout;
    logic        c_rst, c_en, we;
    logic [9:0]  addr;
    logic [31:0] wdata;

    ibnalhaytham_run_ctrl dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .la1_data_in  (din),
        .la1_oenb     (oenb),
        .la1_data_out (dout),
        .core_rst     (c_rst),
        .core_clk_en  (c_en),
        .imem_we      (we),
        .imem_addr    (addr),
        .imem_wdata   (wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    exp_t eq[$];
    wr_t  wq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic t = 1'b0;
    logic [15:0] cs = 16'h0;

    function automatic logic [31:0] get(int sel);
        case (sel)
            0: get = dout;
            1: get = {31'b0, c_rst};
            2: get = {31'b0, c_en};
            3: get = {31'b0, we};
            4: get = {22'b0, addr};
            default: get = wdata;
        endcase
    endfunction

    function automatic logic [31:0] st(logic [1:0] s, logic r, logic h,
                                       logic e, logic g, logic [9:0] a);
`ifdef LOADER_CHECKSUM_EN
        st = {cs, a, g, e, h, r, s};
`else
        st = {16'h0, a, g, e, h, r, s};
`endif
    endfunction

    // status/control monitor
    initial forever begin
        @(negedge clk);
        for (int i = eq.size() - 1; i >= 0; i--) begin
            if (eq[i].cyc <= cyc) begin
                n_cmp++;
                if (eq[i].cyc < cyc || get(eq[i].sel) !== eq[i].exp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", eq[i].nm,
                             cyc, get(eq[i].sel), eq[i].exp);
                end
                eq.delete(i);
            end
        end
    end

    // write-port monitor
    initial forever begin
        @(negedge clk);
        if (!rst && we === 1'b1) begin
            wr_t w;
            n_cmp++;
            if (wq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write got=%h@%h want=none", wdata, addr);
            end else begin
                w = wq.pop_front();
                if (addr !== w.a || wdata !== w.d) begin
                    n_bad++;
                    $display("FAIL write got=%h@%h want=%h@%h", wdata, addr, w.d, w.a);
                end
            end
        end
    end

    task automatic ex(int d, int sel, logic [31:0] v, string nm);
        exp_t x;
        x.cyc = cyc + d;
        x.sel = sel;
        x.exp = v;
        x.nm  = nm;
        eq.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(logic [1:0] op, logic [15:0] p);
        t   = ~t;
        din = {op, t, 13'b0, p};
        tick(1);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        ex(0, 0, 32'h0000_0004, "reset_status");
        ex(0, 1, 1, "reset_core_rst");
        ex(0, 2, 0, "reset_clk_en");
        ex(0, 3, 0, "reset_we");
        ex(0, 4, 0, "reset_addr");
        tick(1);

        cmd(2'b01, 16'h03FF);
        ex(0, 0, st(0, 1, 0, 0, 1, 10'h3FF), "set_addr");
        cmd(2'b10, 16'hBEEF);
        ex(0, 0, st(0, 1, 1, 0, 0, 10'h3FF), "data_lo");
        wq.push_back('{10'h3FF, 32'hDEADBEEF});
        cmd(2'b10, 16'hDEAD);
        cs = 16'h9D9C;
        ex(0, 3, 1, "we_pulse");
        ex(0, 0, st(0, 1, 0, 0, 1, 10'h3FF), "data_hi");
        cmd(2'b00, 16'h0000);
        ex(0, 3, 0, "we_drop");
        ex(0, 4, 10'h000, "addr_wrap");
        ex(0, 0, st(0, 1, 0, 0, 1, 10'h000), "deferred_nop");
        tick(1);
        ex(0, 0, st(0, 1, 0, 0, 0, 10'h000), "nop_accepted");
        tick(1);

        cmd(2'b11, 16'h8005);
        ex(0, 1, 0, "step5_rst");
        for (int i = 0; i < 5; i++) ex(i, 2, 1, "step5_en");
        ex(5, 2, 0, "step5_end");
        ex(5, 0, st(0, 0, 0, 0, 1, 10'h000), "step5_halt");
        tick(7);

        cmd(2'b11, 16'h8000);
        ex(0, 2, 1, "step0_en");
        ex(1, 2, 0, "step0_end");
        ex(1, 0, st(0, 0, 0, 0, 0, 10'h000), "step0_halt");
        tick(3);

        cmd(2'b11, 16'h4000);
        ex(0, 0, st(1, 0, 0, 0, 1, 10'h000), "run");
        ex(0, 2, 1, "run_en");
        cmd(2'b10, 16'h1234);
        ex(0, 0, st(1, 0, 0, 1, 0, 10'h000), "data_in_run_err");
        ex(0, 3, 0, "data_in_run_no_we");
        ex(1, 3, 0, "data_in_run_no_we2");
        cmd(2'b11, 16'h8003);
        ex(0, 0, st(1, 0, 0, 1, 1, 10'h000), "step_in_run");
        cmd(2'b11, 16'h0000);
        ex(0, 2, 0, "halt_en");
        ex(0, 0, st(0, 0, 0, 1, 0, 10'h000), "halt");
        cmd(2'b11, 16'hC000);
        ex(0, 0, st(0, 1, 0, 0, 1, 10'h000), "core_reset");
        tick(1);

        oenb = 32'h2000_0000;
        cmd(2'b01, 16'h0055);
        ex(0, 0, st(0, 1, 0, 0, 1, 10'h000), "oenb_blocked");
        oenb = '0;
        tick(1);
        cs = 16'h0;
        ex(0, 0, st(0, 1, 0, 0, 0, 10'h055), "oenb_released");
        cmd(2'b10, 16'h0001);
        wq.push_back('{10'h055, 32'h0002_0001});
        cmd(2'b10, 16'h0002);
        cs = 16'h0003;
        tick(1);
        ex(0, 0, st(0, 1, 0, 0, 0, 10'h056), "second_write");
        tick(1);

        cmd(2'b11, 16'h800A);
        ex(0, 2, 1, "step10_en");
        tick(2);
        rst = 1'b1;
        din = '0;
        t   = 1'b0;
        cs  = 16'h0;
        #1;
        ex(0, 0, 32'h0000_0004, "midstep_rst_status");
        ex(0, 2, 0, "midstep_rst_en");
        ex(0, 3, 0, "midstep_rst_we");
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ex(i, 2, 0, "post_rst_en");
        ex(3, 0, 32'h0000_0004, "post_rst_status");
        tick(6);

        n_cmp++;
        if (eq.size() != 0 || wq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover got=%0d/%0d want=0/0", eq.size(), wq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
